// File: rtl/loop_gain_detector.sv
// Two-channel I/Q correlator for loop-gain measurement: probe samples are multiplied by an
// NCO cos/sin reference and summed over n_samples; software forms the gain ratio from the sums.
module loop_gain_detector #(
  parameter int DATA_W  = 12,
  parameter int COEF_W  = 12,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int ACC_W   = 40,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [PHASE_W-1:0]        ftw,
  input  logic [CNT_W-1:0]          n_samples,
  input  logic                      smp_valid,
  input  logic signed [DATA_W-1:0]  smp_in,
  input  logic signed [DATA_W-1:0]  smp_out,
  output logic                      busy,
  output logic                      done,
  output logic signed [ACC_W-1:0]   i_in,
  output logic signed [ACC_W-1:0]   q_in,
  output logic signed [ACC_W-1:0]   i_out,
  output logic signed [ACC_W-1:0]   q_out,
  output logic                      overflow
);

  localparam int LUT_N  = 2 ** LUT_AW;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam longint PI_FX = 64'sd3373259426;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Folds the angle into the first quadrant, then a Q30 Taylor series gives cos, rounded to COEF_W.
  function automatic logic signed [COEF_W-1:0] lut_cos(input int k);
    longint m, a, x2, term, sum, amp, v;
    logic neg;
    m   = longint'((k + LUT_N) % LUT_N);
    neg = 1'b0;
    if (m > longint'(LUT_N / 2)) m = longint'(LUT_N) - m;
    if (m > longint'(LUT_N / 4)) begin
      m   = longint'(LUT_N / 2) - m;
      neg = 1'b1;
    end
    a    = (PI_FX * 64'sd2 * m) / longint'(LUT_N);
    x2   = (a * a) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (COEF_W - 1)) - 64'sd1;
    v   = (amp * sum + (64'sd1 <<< 29)) >>> 30;
    if (neg) v = -v;
    return COEF_W'(v);
  endfunction

  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                             input logic signed [PROD_W-1:0] p);
    logic signed [ACC_W:0] s;
    s = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W + 1 - PROD_W){p[PROD_W-1]}}, p});
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic signed [COEF_W-1:0] cos_lut [LUT_N];
  logic signed [COEF_W-1:0] sin_lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign cos_lut[g] = lut_cos(g);
    assign sin_lut[g] = lut_cos(g - LUT_N / 4);
  end

  logic [1:0]         state, drain_cnt;
  logic [CNT_W-1:0]   remaining;
  logic [PHASE_W-1:0] phase, ftw_r;
  logic               accept, start_go;
  logic [LUT_AW-1:0]  lut_idx;

  logic                     vld_s1, vld_s2;
  logic signed [DATA_W-1:0] x_in_s1, x_out_s1;
  logic signed [COEF_W-1:0] cos_s1, sin_s1;
  logic signed [PROD_W-1:0] ext_in, ext_out, ext_cos, ext_sin;
  logic signed [PROD_W-1:0] p_ic, p_is, p_oc, p_os;
  logic signed [ACC_W-1:0]  acc_ic, acc_is, acc_oc, acc_os;
  logic [ACC_W:0]           sum_ic, sum_is, sum_oc, sum_os;

  assign busy     = (state != ST_IDLE);
  assign accept   = (state == ST_RUN) && smp_valid;
  assign start_go = (state == ST_IDLE) && start;
  assign lut_idx  = phase[PHASE_W-1 -: LUT_AW];

  assign ext_in  = $signed({{COEF_W{x_in_s1[DATA_W-1]}}, x_in_s1});
  assign ext_out = $signed({{COEF_W{x_out_s1[DATA_W-1]}}, x_out_s1});
  assign ext_cos = $signed({{DATA_W{cos_s1[COEF_W-1]}}, cos_s1});
  assign ext_sin = $signed({{DATA_W{sin_s1[COEF_W-1]}}, sin_s1});

  assign sum_ic = sat_add(acc_ic, p_ic);
  assign sum_is = sat_add(acc_is, p_is);
  assign sum_oc = sat_add(acc_oc, p_oc);
  assign sum_os = sat_add(acc_os, p_os);

  // Control FSM; published results only change on a completed run or a zero-length start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      remaining <= '0;
      phase     <= '0;
      ftw_r     <= '0;
      done      <= 1'b0;
      i_in      <= '0;
      q_in      <= '0;
      i_out     <= '0;
      q_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_samples != '0) begin
              ftw_r     <= ftw;
              remaining <= n_samples;
              phase     <= '0;
              state     <= ST_RUN;
            end else begin
              i_in  <= '0;
              q_in  <= '0;
              i_out <= '0;
              q_out <= '0;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (smp_valid) begin
            phase     <= phase + ftw_r;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            i_in  <= acc_ic;
            q_in  <= acc_is;
            i_out <= acc_oc;
            q_out <= acc_os;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1   <= 1'b0;
      x_in_s1  <= '0;
      x_out_s1 <= '0;
      cos_s1   <= '0;
      sin_s1   <= '0;
      vld_s2   <= 1'b0;
      p_ic     <= '0;
      p_is     <= '0;
      p_oc     <= '0;
      p_os     <= '0;
    end else begin
      vld_s1 <= accept;
      if (accept) begin
        x_in_s1  <= smp_in;
        x_out_s1 <= smp_out;
        cos_s1   <= cos_lut[lut_idx];
        sin_s1   <= sin_lut[lut_idx];
      end
      vld_s2 <= vld_s1;
      if (vld_s1) begin
        p_ic <= ext_in * ext_cos;
        p_is <= ext_in * ext_sin;
        p_oc <= ext_out * ext_cos;
        p_os <= ext_out * ext_sin;
      end
    end
  end

  // Accumulators clear on any accepted start; overflow stays set until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_ic   <= '0;
      acc_is   <= '0;
      acc_oc   <= '0;
      acc_os   <= '0;
      overflow <= 1'b0;
    end else if (start_go) begin
      acc_ic   <= '0;
      acc_is   <= '0;
      acc_oc   <= '0;
      acc_os   <= '0;
      overflow <= 1'b0;
    end else if (vld_s2) begin
      acc_ic   <= sum_ic[ACC_W-1:0];
      acc_is   <= sum_is[ACC_W-1:0];
      acc_oc   <= sum_oc[ACC_W-1:0];
      acc_os   <= sum_os[ACC_W-1:0];
      overflow <= overflow | sum_ic[ACC_W] | sum_is[ACC_W] | sum_oc[ACC_W] | sum_os[ACC_W];
    end
  end

endmodule

// File: tb/tb_loop_gain_detector.sv
// Bench for loop_gain_detector: a 40-bit and a 24-bit instance share randomized stimulus and are
// compared each cycle against a sample-level correlation model built on a $cos/$sin table.
module tb_loop_gain_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic smp_valid = 1'b0;
  logic [15:0] ftw = '0;
  logic [15:0] n_samples = '0;
  logic signed [11:0] smp_in = '0;
  logic signed [11:0] smp_out = '0;

  logic busy, done, overflow;
  logic signed [39:0] i_in, q_in, i_out, q_out;
  logic busy_s, done_s, overflow_s;
  logic signed [23:0] i_in_s, q_in_s, i_out_s, q_out_s;

  int checks = 0;
  int errors = 0;
  int lut_c [256];
  int lut_s [256];
  logic signed [11:0] in_q [64];
  logic signed [11:0] out_q [64];

  always #5 clk = ~clk;

  loop_gain_detector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ftw(ftw), .n_samples(n_samples),
    .smp_valid(smp_valid), .smp_in(smp_in), .smp_out(smp_out), .busy(busy), .done(done),
    .i_in(i_in), .q_in(q_in), .i_out(i_out), .q_out(q_out), .overflow(overflow)
  );

  loop_gain_detector #(.ACC_W(24)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .ftw(ftw), .n_samples(n_samples),
    .smp_valid(smp_valid), .smp_in(smp_in), .smp_out(smp_out), .busy(busy_s), .done(done_s),
    .i_in(i_in_s), .q_in(q_in_s), .i_out(i_out_s), .q_out(q_out_s), .overflow(overflow_s)
  );

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = 64'sd1 <<< (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic int round_amp(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  // Reference model: per accepted pair, saturating sums of x*cos and x*sin; done 3 edges after last.
  bit m_busy, was_busy, exp_done;
  int m_rem, m_countdown;
  logic [15:0] m_phase, m_ftw;
  longint sum [2][4];
  longint exp_res [2][4];
  bit m_ovf [2];
  int acc_w [2] = '{40, 24};

  initial begin
    longint x, c, t, s;
    int idx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; exp_done = 0; m_rem = 0; m_countdown = 0; m_phase = '0; m_ftw = '0;
        sum = '{default: 0}; exp_res = '{default: 0}; m_ovf = '{default: 0};
      end else begin
        was_busy = m_busy;
        exp_done = 0;
        if (m_countdown > 0) begin
          m_countdown--;
          if (m_countdown == 0) begin
            m_busy = 0;
            exp_done = 1;
            exp_res = sum;
          end
        end
        if (!was_busy && start) begin
          if (n_samples != 0) begin
            m_busy = 1; m_rem = n_samples; m_ftw = ftw; m_phase = '0;
            sum = '{default: 0}; m_ovf = '{default: 0};
          end else begin
            exp_res = '{default: 0}; m_ovf = '{default: 0}; exp_done = 1;
          end
        end else if (m_busy && m_rem > 0 && smp_valid) begin
          idx = int'(m_phase) / 256;
          for (int j = 0; j < 4; j++) begin
            x = (j < 2) ? longint'(smp_in) : longint'(smp_out);
            c = (j % 2 == 0) ? longint'(lut_c[idx]) : longint'(lut_s[idx]);
            for (int w = 0; w < 2; w++) begin
              t = sum[w][j] + x * c;
              s = sat(t, acc_w[w]);
              if (s != t) m_ovf[w] = 1;
              sum[w][j] = s;
            end
          end
          m_phase = m_phase + m_ftw;
          m_rem--;
          if (m_rem == 0) m_countdown = 3;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("busy", busy, m_busy);
        check_output("busy_s", busy_s, m_busy);
        check_output("done", done, exp_done);
        check_output("done_s", done_s, exp_done);
        check_output("i_in", i_in, exp_res[0][0]);
        check_output("q_in", q_in, exp_res[0][1]);
        check_output("i_out", i_out, exp_res[0][2]);
        check_output("q_out", q_out, exp_res[0][3]);
        check_output("i_in_s", i_in_s, exp_res[1][0]);
        check_output("q_in_s", q_in_s, exp_res[1][1]);
        check_output("i_out_s", i_out_s, exp_res[1][2]);
        check_output("q_out_s", q_out_s, exp_res[1][3]);
        if (!m_busy) begin
          check_output("overflow", overflow, m_ovf[0]);
          check_output("overflow_s", overflow_s, m_ovf[1]);
        end
      end
    end
  end

  task automatic fill_const(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin
      in_q[i] = 12'(a);
      out_q[i] = 12'(b);
    end
  endtask

  // gap: 0 = back-to-back, 1 = alternate cycles, 2 = random; mid_start pulses start while busy.
  task automatic apply_stimulus(input logic [15:0] f, input logic [15:0] n, input int gap,
                                input bit mid_start, output int elapsed);
    int sent, cyc;
    bit v;
    smp_valid = 1'b1; smp_in = 12'($urandom); smp_out = 12'($urandom);
    @(negedge clk);
    start = 1'b1; ftw = f; n_samples = n; smp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; ftw = 16'($urandom); n_samples = 16'($urandom);
    check_output("busy_after_start", busy, 1);
    check_output("ovf_cleared", overflow, 0);
    check_output("ovf_s_cleared", overflow_s, 0);
    sent = 0;
    cyc = 0;
    while (sent < int'(n) && cyc < 2000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      smp_valid = v;
      if (v) begin
        smp_in = in_q[sent];
        smp_out = out_q[sent];
        sent++;
        start = mid_start && (sent == 2 || sent == int'(n));
      end else begin
        smp_in = 12'($urandom);
        smp_out = 12'($urandom);
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    smp_valid = 1'b0;
    start = 1'b0;
    elapsed = 0;
    while (!done && elapsed < 10) begin
      @(negedge clk);
      elapsed++;
    end
    check_output("done_latency", elapsed, 3);
  endtask

  task automatic check_t1();
    check_output("t1_i_in", i_in, 818800);
    check_output("t1_q_in", q_in, 0);
    check_output("t1_i_out", i_out, -409400);
    check_output("t1_q_out", q_out, 0);
  endtask

  initial begin : main
    int lat;
    real pi;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 256; k++) begin
      lut_c[k] = round_amp(2047.0 * $cos(2.0 * pi * k / 256.0));
      lut_s[k] = round_amp(2047.0 * $sin(2.0 * pi * k / 256.0));
    end
    check_output("lut_cos0", lut_c[0], 2047);
    check_output("lut_cos64", lut_c[64], 0);
    check_output("lut_cos32", lut_c[32], 1447);
    check_output("lut_sin192", lut_s[192], -2047);

    repeat (3) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_i_in", i_in, 0);
    check_output("rst_q_out", q_out, 0);
    check_output("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] T1 constant samples, ftw=0");
    fill_const(4, 100, -50);
    apply_stimulus(16'd0, 16'd4, 0, 1'b0, lat);
    check_t1();

    $display("[TB] T2 quarter-turn NCO");
    in_q[0] = 12'sd100; in_q[1] = 12'sd0; in_q[2] = -12'sd100; in_q[3] = 12'sd0;
    out_q[0] = 12'sd0; out_q[1] = 12'sd100; out_q[2] = 12'sd0; out_q[3] = -12'sd100;
    apply_stimulus(16'd16384, 16'd4, 0, 1'b0, lat);
    check_output("t2_i_in", i_in, 409400);
    check_output("t2_q_in", q_in, 0);
    check_output("t2_i_out", i_out, 0);
    check_output("t2_q_out", q_out, 409400);

    $display("[TB] T3 zero-length start");
    start = 1'b1; n_samples = '0;
    @(negedge clk);
    start = 1'b0;
    check_output("t3_done", done, 1);
    check_output("t3_busy", busy, 0);
    check_output("t3_i_in", i_in, 0);
    check_output("t3_q_out", q_out, 0);
    @(negedge clk);
    check_output("t3_done_pulse", done, 0);

    $display("[TB] T4 saturation");
    fill_const(3, 2047, -2048);
    apply_stimulus(16'd0, 16'd3, 0, 1'b0, lat);
    check_output("t4_i_in_s", i_in_s, 8388607);
    check_output("t4_i_out_s", i_out_s, -8388608);
    check_output("t4_ovf_s", overflow_s, 1);
    check_output("t4_i_in", i_in, 12570627);
    check_output("t4_ovf", overflow, 0);

    $display("[TB] T5 gapped valid with ignored starts");
    fill_const(4, 100, -50);
    apply_stimulus(16'd0, 16'd4, 1, 1'b1, lat);
    check_t1();

    $display("[TB] T6 reset mid-run");
    @(negedge clk);
    start = 1'b1; ftw = '0; n_samples = 16'd4;
    @(negedge clk);
    start = 1'b0; smp_valid = 1'b1; smp_in = 12'sd100; smp_out = -12'sd50;
    repeat (2) @(negedge clk);
    smp_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_output("t6_i_in", i_in, 0);
    check_output("t6_i_out", i_out, 0);
    check_output("t6_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check_output("t6_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(16'd0, 16'd4, 0, 1'b0, lat);
    check_t1();

    $display("[TB] randomized runs");
    for (int r = 0; r < 14; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        in_q[i] = 12'($urandom);
        out_q[i] = 12'($urandom);
      end
      apply_stimulus(16'($urandom), 16'(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish before 2000000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
